// File: rtl/crc_engine.sv
// rtl/crc_engine.sv - parametrised MSB-first CRC generator/checker
//
// Folds a DATA_W-bit message (i_data[0] first) through a non-reflected CRC,
// BPC bits per clock, and reports the result with a one-cycle finish pulse.
// In check mode the result is also compared against a CRC captured at start.
//
// Ports:
//   i_clk      rising-edge clock
//   i_rst      synchronous active-high reset
//   i_start    message request, sampled only while idle
//   i_mode     0 = generate, 1 = check (captured with i_start)
//   i_data     message, i_data[0] folded first (captured with i_start)
//   i_crc_in   expected CRC for check mode (captured with i_start)
//   o_busy     high while a message is being folded
//   o_finish   one-cycle pulse, o_out/o_crc_err valid in this cycle
//   o_out      final CRC, held until the next finish or reset
//   o_crc_err  check-mode mismatch flag, held like o_out
module crc_engine #(
  parameter int unsigned DATA_W = 50,
  parameter int unsigned CRC_W  = 16,
  parameter logic [CRC_W-1:0] POLY = 16'h8005,
  parameter logic [CRC_W-1:0] INIT = '0,
  parameter int unsigned BPC    = 1
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_start,
  input  logic              i_mode,
  input  logic [0:DATA_W-1] i_data,
  input  logic [CRC_W-1:0]  i_crc_in,
  output logic              o_busy,
  output logic              o_finish,
  output logic [CRC_W-1:0]  o_out,
  output logic              o_crc_err
);

  localparam int unsigned CNT_W = $clog2(DATA_W + 1);

  if ((BPC == 0) || (DATA_W % BPC != 0)) begin : g_bad_bpc
    $error("crc_engine: DATA_W must be a non-zero multiple of BPC");
  end
  if ((CRC_W < 1) || (CRC_W > 32)) begin : g_bad_crc_w
    $error("crc_engine: CRC_W must be in 1..32");
  end

  typedef enum logic {IDLE, RUN} state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [CRC_W-1:0]    r_crc;
  logic [CNT_W-1:0]    r_cnt;
  logic [0:DATA_W-1]   r_data;
  logic                r_mode;
  logic [CRC_W-1:0]    r_crc_in;
  logic                r_finish;
  logic [CRC_W-1:0]    r_out;
  logic                r_crc_err;
  logic [CRC_W-1:0]    w_crc_fold;
  logic                w_fb;
  logic                w_last;

  // The captured message shifts toward index 0 each RUN cycle, so the
  // current chunk always sits in r_data[0 .. BPC-1].
  always_comb begin
    w_crc_fold = r_crc;
    w_fb       = 1'b0;
    for (int i = 0; i < int'(BPC); i++) begin
      w_fb       = w_crc_fold[CRC_W-1] ^ r_data[i];
      w_crc_fold = (w_crc_fold << 1) ^ (w_fb ? POLY : '0);
    end
  end

  assign w_last = (r_cnt == CNT_W'(DATA_W - BPC));

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE: if (i_start) w_state_nxt = RUN;
      RUN:  if (w_last)  w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state   <= IDLE;
      r_crc     <= '0;
      r_cnt     <= '0;
      r_data    <= '0;
      r_mode    <= 1'b0;
      r_crc_in  <= '0;
      r_finish  <= 1'b0;
      r_out     <= '0;
      r_crc_err <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_finish <= 1'b0;
      if (r_state == IDLE) begin
        if (i_start) begin
          r_data   <= i_data;
          r_mode   <= i_mode;
          r_crc_in <= i_crc_in;
          r_crc    <= INIT;
          r_cnt    <= '0;
        end
      end else begin
        r_crc  <= w_crc_fold;
        r_cnt  <= r_cnt + CNT_W'(BPC);
        r_data <= r_data << BPC;
        if (w_last) begin
          r_out     <= w_crc_fold;
          r_finish  <= 1'b1;
          r_crc_err <= r_mode & (w_crc_fold != r_crc_in);
        end
      end
    end
  end

  assign o_busy    = (r_state == RUN);
  assign o_finish  = r_finish;
  assign o_out     = r_out;
  assign o_crc_err = r_crc_err;

endmodule

// File: tb/tb_crc_engine.sv
// tb/tb_crc_engine.sv - self-checking bench for crc_engine (BPC=1 and BPC=5)
module tb_crc_engine;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start1 = 1'b0;
  logic        start5 = 1'b0;
  logic        mode = 1'b0;
  logic [0:49] data = '0;
  logic [15:0] crc_in = '0;
  logic        busy1, fin1, err1, busy5, fin5, err5;
  logic [15:0] out1, out5;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  crc_engine #(.DATA_W(50), .CRC_W(16), .POLY(16'h8005), .INIT(16'h0000), .BPC(1)) dut1 (
    .i_clk(clk), .i_rst(rst), .i_start(start1), .i_mode(mode), .i_data(data),
    .i_crc_in(crc_in), .o_busy(busy1), .o_finish(fin1), .o_out(out1), .o_crc_err(err1));

  crc_engine #(.DATA_W(50), .CRC_W(16), .POLY(16'h8005), .INIT(16'h0000), .BPC(5)) dut5 (
    .i_clk(clk), .i_rst(rst), .i_start(start5), .i_mode(mode), .i_data(data),
    .i_crc_in(crc_in), .o_busy(busy5), .o_finish(fin5), .o_out(out5), .o_crc_err(err5));

  // Reference: remainder of M(x)*x^16 modulo G(x)=x^16+x^15+x^2+1 by long division.
  function automatic logic [15:0] ref_crc(input logic [0:49] d);
    logic [65:0] v;
    v = {d, 16'h0000};
    for (int i = 65; i >= 16; i--)
      if (v[i]) v[i -: 17] = v[i -: 17] ^ 17'h18005;
    return v[15:0];
  endfunction

  function automatic logic [0:49] rand50();
    logic [63:0] t;
    t = {$urandom, $urandom};
    return t[49:0];
  endfunction

  function automatic logic get_fin(input int w);
    return (w == 5) ? fin5 : fin1;
  endfunction
  function automatic logic get_busy(input int w);
    return (w == 5) ? busy5 : busy1;
  endfunction
  function automatic logic [15:0] get_out(input int w);
    return (w == 5) ? out5 : out1;
  endfunction
  function automatic logic get_err(input int w);
    return (w == 5) ? err5 : err1;
  endfunction

  task automatic set_start(input int w, input logic v);
    if (w == 5) start5 = v; else start1 = v;
  endtask

  // Drives one message and records what the DUT did; no checking here.
  task automatic run_one(input int w, input logic [0:49] d, input logic m,
                         input logic [15:0] ci, input bit noise,
                         output logic [15:0] o, output logic e, output int lat,
                         output int bcnt, output bit overlap, output bit wide);
    @(negedge clk);
    data = d; mode = m; crc_in = ci;
    set_start(w, 1'b1);
    @(posedge clk);
    @(negedge clk);
    set_start(w, 1'b0);
    lat = -1; bcnt = 0; overlap = 1'b0; o = 'x; e = 1'bx;
    for (int k = 0; k < 200; k++) begin
      if (get_fin(w)) begin
        lat = k + 1; o = get_out(w); e = get_err(w);
        overlap = get_busy(w);
        break;
      end
      if (get_busy(w)) bcnt++;
      if (noise) begin
        data = rand50(); mode = 1'($urandom); crc_in = 16'($urandom);
        set_start(w, 1'($urandom));
      end
      @(negedge clk);
    end
    set_start(w, 1'b0);
    @(negedge clk);
    wide = get_fin(w);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    total++; if ({busy1, fin1, err1} !== 3'b000) begin bad++; $display("FAIL reset_flags1 got %b want 000", {busy1, fin1, err1}); end
    total++; if (out1 !== 16'h0) begin bad++; $display("FAIL reset_out1 got %h want 0000", out1); end
    total++; if ({busy5, fin5, err5} !== 3'b000) begin bad++; $display("FAIL reset_flags5 got %b want 000", {busy5, fin5, err5}); end
    total++; if (out5 !== 16'h0) begin bad++; $display("FAIL reset_out5 got %h want 0000", out5); end
    rst = 1'b0;
  endtask

  // Directed vectors on one DUT; n = expected chunk count.
  task automatic test_directed(input int w, input int n);
    logic [15:0] o; logic e; int lat, bc; bit ov, wd;
    logic [0:49] d;
    d = '0;
    run_one(w, d, 1'b0, 16'h0, 1'b0, o, e, lat, bc, ov, wd);
    total++; if (lat !== n + 1) begin bad++; $display("FAIL zero_latency dut%0d got %0d want %0d", w, lat, n + 1); end
    total++; if (bc !== n) begin bad++; $display("FAIL zero_busy dut%0d got %0d want %0d", w, bc, n); end
    total++; if (o !== 16'h0000 || e !== 1'b0) begin bad++; $display("FAIL zero_out dut%0d got %h/%b want 0000/0", w, o, e); end
    total++; if (ov !== 1'b0 || wd !== 1'b0) begin bad++; $display("FAIL finish_shape dut%0d overlap=%b wide=%b want 0/0", w, ov, wd); end
    d = '0; d[49] = 1'b1;
    run_one(w, d, 1'b0, 16'h0, 1'b0, o, e, lat, bc, ov, wd);
    total++; if (o !== 16'h8005 || e !== 1'b0) begin bad++; $display("FAIL bit49 dut%0d got %h/%b want 8005/0", w, o, e); end
    d = '0; d[48] = 1'b1;
    run_one(w, d, 1'b0, 16'h0, 1'b0, o, e, lat, bc, ov, wd);
    total++; if (o !== 16'h800F || e !== 1'b0) begin bad++; $display("FAIL bit48 dut%0d got %h/%b want 800f/0", w, o, e); end
    d = '0; d[49] = 1'b1;
    run_one(w, d, 1'b1, 16'h8005, 1'b0, o, e, lat, bc, ov, wd);
    total++; if (o !== 16'h8005 || e !== 1'b0) begin bad++; $display("FAIL check_match dut%0d got %h/%b want 8005/0", w, o, e); end
    run_one(w, d, 1'b1, 16'h8004, 1'b0, o, e, lat, bc, ov, wd);
    total++; if (o !== 16'h8005 || e !== 1'b1) begin bad++; $display("FAIL check_mismatch dut%0d got %h/%b want 8005/1", w, o, e); end
    total++; if (lat !== n + 1) begin bad++; $display("FAIL check_latency dut%0d got %0d want %0d", w, lat, n + 1); end
  endtask

  // Random messages with input noise (including ignored start pulses) while busy.
  task automatic test_random(input int w, input int n);
    logic [15:0] o, exp_o, ci; logic e, m, exp_e; int lat, bc; bit ov, wd;
    logic [0:49] d;
    for (int t = 0; t < 6; t++) begin
      d = rand50(); m = 1'($urandom);
      exp_o = ref_crc(d);
      ci = ($urandom % 2) ? exp_o : (exp_o ^ (16'h1 << ($urandom % 16)));
      exp_e = m & (ci != exp_o);
      run_one(w, d, m, ci, 1'b1, o, e, lat, bc, ov, wd);
      total++; if (o !== exp_o || e !== exp_e || lat !== n + 1)
        begin bad++; $display("FAIL random dut%0d #%0d got %h/%b lat %0d want %h/%b lat %0d", w, t, o, e, lat, exp_o, exp_e, n + 1); end
    end
  endtask

  task automatic test_back_to_back();
    logic [0:49] msgs [3];
    int fin_t [3];
    int nf;
    bit prev_fin;
    for (int i = 0; i < 3; i++) msgs[i] = rand50();
    nf = 0; prev_fin = 1'b0;
    @(negedge clk);
    data = msgs[0]; mode = 1'b0; crc_in = 16'h0; start1 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    data = msgs[1];
    for (int cyc = 1; cyc <= 200; cyc++) begin
      if (prev_fin) begin
        if (nf == 1) data = msgs[2];
        else if (nf == 2) begin start1 = 1'b0; data = rand50(); end
        prev_fin = 1'b0;
      end
      if (fin1) begin
        fin_t[nf] = cyc;
        total++; if (out1 !== ref_crc(msgs[nf]))
          begin bad++; $display("FAIL b2b_out #%0d got %h want %h", nf, out1, ref_crc(msgs[nf])); end
        nf++; prev_fin = 1'b1;
        if (nf == 3) break;
      end
      @(negedge clk);
    end
    start1 = 1'b0;
    total++; if (nf !== 3) begin bad++; $display("FAIL b2b_count got %0d want 3", nf); end
    else begin
      total++; if (fin_t[0] !== 51 || fin_t[1] !== 102 || fin_t[2] !== 153)
        begin bad++; $display("FAIL b2b_timing got %0d,%0d,%0d want 51,102,153", fin_t[0], fin_t[1], fin_t[2]); end
    end
    @(negedge clk);
  endtask

  task automatic test_rst_abort();
    logic [15:0] o; logic e; int lat, bc, nfin; bit ov, wd;
    logic [0:49] d;
    d = rand50(); d[0] = 1'b1;
    @(negedge clk);
    data = d; mode = 1'b1; crc_in = 16'h1234; start1 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start1 = 1'b0;
    repeat (19) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    total++; if ({busy1, fin1, err1} !== 3'b000 || out1 !== 16'h0)
      begin bad++; $display("FAIL abort_outputs got busy=%b fin=%b err=%b out=%h want 0", busy1, fin1, err1, out1); end
    nfin = 0;
    repeat (60) begin @(negedge clk); if (fin1) nfin++; end
    total++; if (nfin !== 0) begin bad++; $display("FAIL abort_no_finish got %0d finishes want 0", nfin); end
    run_one(1, d, 1'b0, 16'h0, 1'b0, o, e, lat, bc, ov, wd);
    total++; if (o !== ref_crc(d) || e !== 1'b0 || lat !== 51)
      begin bad++; $display("FAIL after_abort got %h/%b lat %0d want %h/0 lat 51", o, e, lat, ref_crc(d)); end
  endtask

  initial begin
    test_reset();
    test_directed(1, 50);
    test_directed(5, 10);
    test_random(1, 50);
    test_random(5, 10);
    test_back_to_back();
    test_rst_abort();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/crc_engine.md
# crc_engine

Parametrised CRC generator/checker for the sender/receiver data path. It accepts a DATA_W-bit message on a start strobe and folds it through an MSB-first, non-reflected CRC. It processes BPC bits per clock and reports the CRC with a one-cycle finish pulse. In check mode it also compares the result against a supplied CRC and flags a mismatch, so one block serves both the sender (generate) and the receiver (verify).

## Interface
- DATA_W, 50: message width in bits.
- CRC_W, 16: CRC width, 1..32.
- POLY, 16'h8005: generator polynomial without the implicit x^CRC_W term.
- INIT, 0: CRC register preset at the start of each message.
- BPC, 1: bits folded per clock. DATA_W % BPC must be 0; an elaboration-time check rejects any other value.

- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- start  in  1  message request; sampled only when busy=0.
- mode  in  1  0 = generate, 1 = check; captured with start.
- data  in  [0:DATA_W-1]  message; data[0] is folded first.
- crc_in  in  CRC_W  expected CRC for check mode; captured with start.
- busy  out  1  high while a message is being folded.
- finish  out  1  one-cycle pulse; out and crc_err are valid in this cycle.
- out  out  CRC_W  final CRC; held until the next finish or reset.
- crc_err  out  1  check mode: result != captured crc_in. Generate mode: 0. Held like out.

## Operation
- States: IDLE, RUN.
- IDLE:
  - start=1 captures data, mode and crc_in into internal registers.
  - It also sets crc = INIT and bit counter cnt = 0, and moves to RUN. busy goes to 1.
- RUN: each clock folds the BPC bits data_reg[cnt .. cnt+BPC-1] in index order, then cnt += BPC.
  - Per bit b: fb = crc[CRC_W-1] ^ b; crc = (crc << 1) ^ (fb ? POLY : 0), truncated to CRC_W bits.
  - Equivalent to the BPC-deep unrolled combinational chain of this step.
- Final chunk (cnt + BPC == DATA_W), on the same edge:
  - out <= new crc, finish <= 1.
  - crc_err <= mode & (new crc != crc_in_reg).
  - busy <= 0, state <= IDLE.
- start while busy=1 is ignored. It is not queued and does not disturb captured inputs.
- start in the finish cycle (busy=0) is accepted, giving back-to-back messages.
- Changes on data, mode or crc_in after capture have no effect on the message in flight.
- Counter width is clog2(DATA_W+1). cnt never exceeds DATA_W.

## Timing
- Reset values: busy=0, finish=0, out=0, crc_err=0. State is IDLE, crc and cnt are 0.
- rst has priority over start.
- rst in RUN aborts the message. busy, finish, out and crc_err are 0 on the next cycle, and no finish follows for the aborted message.
- Latency, with N = DATA_W/BPC:
  - start sampled at edge E0; chunks are folded at edges E1..EN.
  - finish is high in the cycle after EN, i.e. N+1 cycles after start is sampled.
- busy is high from the cycle after E0 through the cycle before finish.
- finish is exactly one cycle wide and never coincides with busy=1.
- Throughput: one message per N+1 cycles with start held high.
- Defaults (N=50): finish 51 cycles after start. With BPC=5 (N=10): 11 cycles.

## Test plan
- Default params, data all 0, mode=0, one start pulse -> busy high for 50 cycles. finish pulses once in cycle 51; out=16'h0000, crc_err=0.
- Default params, only data[49]=1 -> out=16'h8005. Only data[48]=1 -> out=16'h800F. Both in generate mode with crc_err=0.
- mode=1, only data[49]=1:
  - crc_in=16'h8005 -> crc_err=0.
  - crc_in=16'h8004 -> crc_err=1, out=16'h8005.
- BPC=5, same vectors as the two scenarios above -> identical out and crc_err values, with finish 11 cycles after start.
- start held high for 3 messages with different data -> three finish pulses 51 cycles apart, each out correct. start pulses during busy leave results unchanged.
- rst asserted at RUN cycle 20 -> all outputs 0 on the next cycle, no finish. A fresh start afterwards completes normally with the correct CRC.
